syscall_ctrl: RTL

Sequencing controller for the CPU's syscall service path. It decodes `in_v0` when the datapath presents a syscall, and stalls the PC while it delivers `in_a0` to the display sink over a valid/ready handshake. It halts the core on exit until resumed, and releases the PC for exactly one cycle so the syscall instruction retires once. It sits between the single-cycle datapath (syscall decode, `$v0`/`$a0` read ports, PC write-enable) and the display unit.

---
 rtl/syscall_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/syscall_ctrl.sv
// ============================================================================
// Module   : syscall_ctrl
// Purpose  : Syscall sequencer - display send, exit halt, single-cycle retire.
//            Optional macro SYSCALL_COUNT_EN enables the accepted-syscall count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module syscall_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        in_CLK,
    input  logic        in_RST_N,
    input  logic        in_syscall,
    input  logic [31:0] in_v0,
    input  logic [31:0] in_a0,
    input  logic        in_disp_ready,
    input  logic        in_resume,
    output logic        out_stall,
    output logic        out_disp_valid,
    output logic [31:0] out_disp_data,
    output logic        out_disp_hex,
    output logic        out_halted,
    output logic [1:0]  out_err,
    output logic [15:0] out_count
);

    localparam logic [1:0]  S_IDLE = 2'd0;
    localparam logic [1:0]  S_SEND = 2'd1;
    localparam logic [1:0]  S_DONE = 2'd2;
    localparam logic [1:0]  S_HALT = 2'd3;
    localparam logic [15:0] C_TMO_LAST = 16'(TIMEOUT - 1);

    logic [1:0]  r_state;
    logic [1:0]  w_next;
    logic [15:0] r_timer;
    logic [31:0] r_data;
    logic        r_hex;
    logic [1:0]  r_err;
    logic        w_is_disp;
    logic        w_is_exit;
    logic        w_svc_call;
    logic        w_tmo_hit;
    logic        w_stall;

    // Full 32-bit compares: only the exact service numbers are recognised.
    assign w_is_disp  = (in_v0 == 32'd1) || (in_v0 == 32'd34);
    assign w_is_exit  = (in_v0 == 32'd10);
    assign w_svc_call = (r_state == S_IDLE) && in_syscall;
    assign w_tmo_hit  = (r_timer == C_TMO_LAST) && !in_disp_ready;

    always_ff @(posedge in_CLK or negedge in_RST_N) begin
        if (!in_RST_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_svc_call && w_is_disp) begin
                    w_next = S_SEND;
                end else if (w_svc_call && w_is_exit) begin
                    w_next = S_HALT;
                end
            end
            S_SEND: begin
                if (in_disp_ready || w_tmo_hit) begin
                    w_next = S_DONE;
                end
            end
            S_HALT: begin
                if (in_resume) begin
                    w_next = S_DONE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Stall in IDLE must be combinational so the PC never advances on the
    // syscall's own detect cycle; it is forced low while reset is held.
    always_comb begin
        w_stall = 1'b0;
        case (r_state)
            S_IDLE:  w_stall = in_syscall && (w_is_disp || w_is_exit);
            S_SEND:  w_stall = 1'b1;
            S_HALT:  w_stall = 1'b1;
            default: w_stall = 1'b0;
        endcase
    end

    assign out_stall      = w_stall && in_RST_N;
    assign out_disp_valid = (r_state == S_SEND);
    assign out_halted     = (r_state == S_HALT);
    assign out_disp_data  = r_data;
    assign out_disp_hex   = r_hex;
    assign out_err        = r_err;

    always_ff @(posedge in_CLK or negedge in_RST_N) begin
        if (!in_RST_N) begin
            r_timer <= 16'd0;
            r_data  <= 32'd0;
            r_hex   <= 1'b0;
            r_err   <= 2'b00;
        end else begin
            if (w_svc_call && w_is_disp) begin
                r_data  <= in_a0;
                r_hex   <= (in_v0 == 32'd34);
                r_timer <= 16'd0;
            end else if ((r_state == S_SEND) && !in_disp_ready && !w_tmo_hit) begin
                r_timer <= r_timer + 16'd1;
            end
            if (w_svc_call && !w_is_disp && !w_is_exit) begin
                r_err[0] <= 1'b1;
            end
            if ((r_state == S_SEND) && w_tmo_hit) begin
                r_err[1] <= 1'b1;
            end
        end
    end

`ifdef SYSCALL_COUNT_EN
    logic [15:0] r_count;

    always_ff @(posedge in_CLK or negedge in_RST_N) begin
        if (!in_RST_N) begin
            r_count <= 16'd0;
        end else if (w_svc_call && (w_is_disp || w_is_exit)) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign out_count = r_count;
`else
    assign out_count = 16'd0;
`endif

endmodule

`default_nettype wire
